bist_lfsr_misr: RTL

Built-in self-test wrapper stage for the ISCAS-85 combinational netlists mapped onto the team's standard-cell library. Upstream, a Galois LFSR drives pseudo-random patterns onto the circuit-under-test (CUT) primary inputs. Downstream, a MISR compacts the CUT primary outputs into a signature. A small FSM sequences seed load, pattern run and golden-signature compare. The CUT is purely combinational, so pattern and response share one clock cycle.

---
 rtl/bist_pkg.sv | 34 +++
 rtl/galois_step.sv | 14 +
 rtl/bist_lfsr_misr.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and default tap masks for the LFSR/MISR built-in self-test wrapper.
// The polynomial masks use the right-shifting Galois form: bit i set means feedback into bit i.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CMP,
    ST_DONE
  } bist_state_e;

  // c432: 36 primary inputs, 7 primary outputs
  localparam int unsigned          C432_WIDTH_IN   = 36;
  localparam int unsigned          C432_WIDTH_OUT  = 7;
  localparam int unsigned          C432_SIG_W      = 16;
  localparam logic [35:0]          C432_LFSR_POLY  = 36'h800000CDD;
  localparam logic [15:0]          C432_MISR_POLY  = 16'hB400;

  // c880: 60 primary inputs, 26 primary outputs
  localparam int unsigned          C880_WIDTH_IN   = 60;
  localparam int unsigned          C880_WIDTH_OUT  = 26;
  localparam int unsigned          C880_SIG_W      = 32;
  localparam logic [59:0]          C880_LFSR_POLY  = 60'hC00000000000000;
  localparam logic [31:0]          C880_MISR_POLY  = 32'hA3000000;

  // c1908: 33 primary inputs, 25 primary outputs
  localparam int unsigned          C1908_WIDTH_IN  = 33;
  localparam int unsigned          C1908_WIDTH_OUT = 25;
  localparam int unsigned          C1908_SIG_W     = 32;
  localparam logic [32:0]          C1908_LFSR_POLY = 33'h100080000;
  localparam logic [31:0]          C1908_MISR_POLY = 32'hA3000000;

endpackage

// File: rtl/galois_step.sv
// One step of a right-shifting Galois shift register with an XOR data input.
// Used with din tied to zero as a pattern LFSR and with the CUT response as a MISR.
module galois_step #(
  parameter int unsigned     W    = 16,
  parameter logic [W-1:0]    POLY = '0
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] din,
  output logic [W-1:0] nxt
);

  assign nxt = (cur >> 1) ^ (cur[0] ? POLY : '0) ^ din;

endmodule

// File: rtl/bist_lfsr_misr.sv
// BIST wrapper: an LFSR drives the CUT inputs, a MISR compacts the CUT outputs, and an FSM
// sequences seed load, the pattern run and the golden-signature compare.
module bist_lfsr_misr
  import bist_pkg::*;
#(
  parameter int unsigned            WIDTH_IN     = 36,
  parameter int unsigned            WIDTH_OUT    = 7,
  parameter int unsigned            SIG_W        = 16,
  parameter logic [WIDTH_IN-1:0]    LFSR_POLY    = C432_LFSR_POLY,
  parameter logic [SIG_W-1:0]       MISR_POLY    = C432_MISR_POLY,
  parameter logic [WIDTH_IN-1:0]    SEED         = WIDTH_IN'(1),
  parameter int unsigned            NUM_PATTERNS = 1024,
  parameter logic [SIG_W-1:0]       GOLDEN       = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [WIDTH_OUT-1:0]  PO,
  output logic [WIDTH_IN-1:0]   PI,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [SIG_W-1:0]      SIGNATURE
);

  localparam int unsigned         CNT_W    = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0]    LAST     = CNT_W'(NUM_PATTERNS - 1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [WIDTH_IN-1:0] SEED_EFF = (SEED == '0) ? WIDTH_IN'(1) : SEED;

  bist_state_e          state;
  logic [WIDTH_IN-1:0]  lfsr_q;
  logic [WIDTH_IN-1:0]  lfsr_nxt;
  logic [SIG_W-1:0]     misr_q;
  logic [SIG_W-1:0]     misr_nxt;
  logic [SIG_W-1:0]     po_ext;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    po_ext                = '0;
    po_ext[WIDTH_OUT-1:0] = PO;
  end

  galois_step #(
    .W    (WIDTH_IN),
    .POLY (LFSR_POLY)
  ) u_lfsr_step (
    .cur (lfsr_q),
    .din ('0),
    .nxt (lfsr_nxt)
  );

  galois_step #(
    .W    (SIG_W),
    .POLY (MISR_POLY)
  ) u_misr_step (
    .cur (misr_q),
    .din (po_ext),
    .nxt (misr_nxt)
  );

  // BUSY/DONE are registered alongside the state so they change on the same edge.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      lfsr_q <= '0;
      misr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state  <= ST_LOAD;
            busy_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          lfsr_q <= SEED_EFF;
          misr_q <= '0;
          cnt_q  <= '0;
          pass_q <= 1'b0;
          state  <= ST_RUN;
        end
        ST_RUN: begin
          lfsr_q <= lfsr_nxt;
          misr_q <= misr_nxt;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state <= ST_CMP;
          end
        end
        ST_CMP: begin
          pass_q <= (misr_q == GOLDEN);
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          if (START) begin
            done_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign PI        = lfsr_q;
  assign SIGNATURE = misr_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;

endmodule
